// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: resolves exception, eret, halt, stall and branch requests into next-PC controls.
// Optional macro FETCH_CTRL_PERF_EN adds the stall_cycles_o performance counter.
module fetch_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_req_i,
  input  logic        branch_req_i,
  input  logic [31:0] branch_target_i,
  input  logic        exc_req_i,
  input  logic        eret_req_i,
  input  logic [31:0] epc_i,
  input  logic        if_error_i,
  input  logic        halt_req_i,
  output logic        pc_enable_o,
  output logic [1:0]  pc_sel_o,
  output logic [31:0] pc_update_o,
  output logic        flush_if_o,
  output logic        fetch_valid_o,
  output logic [1:0]  state_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    EXC   = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [1:0]  SEL_SEQ    = 2'd0;
  localparam logic [1:0]  SEL_BRANCH = 2'd1;
  localparam logic [1:0]  SEL_HANDLR = 2'd2;
  localparam logic [1:0]  SEL_EPC    = 2'd3;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  state_e state_q;
  state_e state_d;
  logic   exc_s;

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetched instruction is real only in RUN/STALL and never while in reset.
  always_comb begin
    fetch_valid_o = 1'b0;
    if (rst_i) begin
      fetch_valid_o = 1'b0;
    end else begin
      fetch_valid_o = (state_q == RUN) || (state_q == STALL);
    end
  end

  // A fetch error only counts against an instruction that is actually valid.
  assign exc_s = exc_req_i || (if_error_i && fetch_valid_o);

  // Reset reports RUN immediately, before the register has been clocked.
  assign state_o = rst_i ? RUN : state_q;

  // Request resolution: exception > eret > halt > stall > branch > sequential.
  always_comb begin
    state_d     = state_q;
    pc_enable_o = 1'b0;
    pc_sel_o    = SEL_SEQ;
    pc_update_o = 32'h0000_0000;
    flush_if_o  = 1'b0;
    if (rst_i) begin
      state_d    = RUN;
      flush_if_o = 1'b1;
    end else begin
      case (state_q)
        HALT: begin
          state_d = HALT;
        end
        RUN, STALL, EXC: begin
          if (exc_s) begin
            pc_enable_o = 1'b1;
            pc_sel_o    = SEL_HANDLR;
            pc_update_o = EXC_VECTOR;
            flush_if_o  = 1'b1;
            state_d     = EXC;
          end else if (eret_req_i) begin
            pc_enable_o = 1'b1;
            pc_sel_o    = SEL_EPC;
            pc_update_o = epc_i;
            flush_if_o  = 1'b1;
            state_d     = RUN;
          end else if (halt_req_i) begin
            state_d = HALT;
          end else if (stall_req_i) begin
            // Any simultaneous branch is dropped; the requester re-presents it.
            state_d = STALL;
          end else if (branch_req_i && (state_q == RUN)) begin
            pc_enable_o = 1'b1;
            pc_sel_o    = SEL_BRANCH;
            pc_update_o = branch_target_i;
            state_d     = RUN;
          end else begin
            pc_enable_o = 1'b1;
            state_d     = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;

  // Counts cycles the PC is held outside HALT; wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= 32'h0000_0000;
    end else if (!pc_enable_o && (state_q != HALT)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_q <= stall_cycles_q;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z32 = 32'h0000_0000;
  localparam logic [31:0] VEC = 32'h0000_4180;

  logic        clk;
  logic        rst;
  logic        stall_req;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        if_error;
  logic        halt_req;
  logic        pc_enable;
  logic [1:0]  pc_sel;
  logic [31:0] pc_update;
  logic        flush_if;
  logic        fetch_valid;
  logic [1:0]  state;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct {
    int          row;
    logic [1:0]  st;
    logic        en;
    logic [1:0]  sel;
    logic [31:0] upd;
    logic        fl;
    logic        fv;
    logic        chk_sc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fails;
  int   row_cnt;
  bit   drive_done;

  fetch_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_req_i     (stall_req),
    .branch_req_i    (branch_req),
    .branch_target_i (branch_target),
    .exc_req_i       (exc_req),
    .eret_req_i      (eret_req),
    .epc_i           (epc),
    .if_error_i      (if_error),
    .halt_req_i      (halt_req),
    .pc_enable_o     (pc_enable),
    .pc_sel_o        (pc_sel),
    .pc_update_o     (pc_update),
    .flush_if_o      (flush_if),
    .fetch_valid_o   (fetch_valid),
    .state_o         (state)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .stall_cycles_o  (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] expv);
    n_checks = n_checks + 1;
    if (act !== expv) begin
      n_fails = n_fails + 1;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, expv);
    end
  endtask

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic drive(input logic r, input logic s, input logic b, input logic x,
                       input logic e, input logic ie, input logic h,
                       input logic [31:0] bt, input logic [31:0] ep,
                       input logic [1:0] st, input logic en, input logic [1:0] sel,
                       input logic [31:0] upd, input logic fl, input logic fv,
                       input logic csc, input logic [31:0] sc);
    exp_t e_v;
    @(posedge clk);
    #1;
    rst = r; stall_req = s; branch_req = b; exc_req = x;
    eret_req = e; if_error = ie; halt_req = h;
    branch_target = bt; epc = ep;
    row_cnt = row_cnt + 1;
    e_v.row = row_cnt; e_v.st = st; e_v.en = en; e_v.sel = sel; e_v.upd = upd;
    e_v.fl = fl; e_v.fv = fv; e_v.chk_sc = csc; e_v.sc = sc;
    exp_q.push_back(e_v);
  endtask

  // Monitor: outputs are combinational, so one expectation is consumed every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e_m;
      e_m = exp_q.pop_front();
      chk("state",       e_m.row, {30'd0, state},       {30'd0, e_m.st});
      chk("pc_enable",   e_m.row, {31'd0, pc_enable},   {31'd0, e_m.en});
      chk("pc_sel",      e_m.row, {30'd0, pc_sel},      {30'd0, e_m.sel});
      chk("pc_update",   e_m.row, pc_update,            e_m.upd);
      chk("flush_if",    e_m.row, {31'd0, flush_if},    {31'd0, e_m.fl});
      chk("fetch_valid", e_m.row, {31'd0, fetch_valid}, {31'd0, e_m.fv});
`ifdef FETCH_CTRL_PERF_EN
      if (e_m.chk_sc) begin
        chk("stall_cycles", e_m.row, stall_cycles, e_m.sc);
      end
`endif
    end
  end

  initial begin
    n_checks = 0; n_fails = 0; row_cnt = 0; drive_done = 1'b0;
    rst = 1'b1; stall_req = 1'b0; branch_req = 1'b0; exc_req = 1'b0;
    eret_req = 1'b0; if_error = 1'b0; halt_req = 1'b0;
    branch_target = Z32; epc = Z32;
    //      r  s  b  x  e  ie h  bt            epc           st    en sel   upd           fl fv chk sc
    // Reset for two cycles, then idle sequential fetch.
    drive(H, L, L, L, L, L, L, Z32,          Z32,          2'd0, L, 2'd0, Z32,          H, L, L, Z32);
    drive(H, L, L, L, L, L, L, Z32,          Z32,          2'd0, L, 2'd0, Z32,          H, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, H, Z32);
    // Three-cycle stall with a branch in the middle cycle that must be dropped.
    drive(L, H, L, L, L, L, L, Z32,          Z32,          2'd0, L, 2'd0, Z32,          L, H, L, Z32);
    drive(L, H, H, L, L, L, L, 32'h0000_1234, Z32,         2'd1, L, 2'd0, Z32,          L, H, L, Z32);
    drive(L, H, L, L, L, L, L, Z32,          Z32,          2'd1, L, 2'd0, Z32,          L, H, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd1, H, 2'd0, Z32,          L, H, H, 32'd3);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, L, Z32);
    // Branch in RUN keeps the delay slot.
    drive(L, L, H, L, L, L, L, 32'h0000_2000, Z32,         2'd0, H, 2'd1, 32'h0000_2000, L, H, L, Z32);
    // Exception beats a simultaneous branch; one EXC cycle then RUN.
    drive(L, L, H, H, L, L, L, 32'h0000_2000, Z32,         2'd0, H, 2'd2, VEC,          H, H, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd2, H, 2'd0, Z32,          L, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, L, Z32);
    // Return from exception.
    drive(L, L, L, L, H, L, L, Z32,          32'h0000_3010, 2'd0, H, 2'd3, 32'h0000_3010, H, H, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, L, Z32);
    // Fetch error acts as an exception in RUN and is masked in EXC.
    drive(L, L, L, L, L, H, L, Z32,          Z32,          2'd0, H, 2'd2, VEC,          H, H, L, Z32);
    drive(L, L, L, L, L, H, L, Z32,          Z32,          2'd2, H, 2'd0, Z32,          L, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, L, Z32);
    // Back-to-back exceptions stay in EXC.
    drive(L, L, L, H, L, L, L, Z32,          Z32,          2'd0, H, 2'd2, VEC,          H, H, L, Z32);
    drive(L, L, L, H, L, L, L, Z32,          Z32,          2'd2, H, 2'd2, VEC,          H, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd2, H, 2'd0, Z32,          L, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, L, Z32);
    // Priority: exception over eret and halt.
    drive(L, L, L, H, H, L, H, Z32,          32'h0000_0400, 2'd0, H, 2'd2, VEC,          H, H, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd2, H, 2'd0, Z32,          L, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, L, Z32);
    // Priority: eret over halt and stall.
    drive(L, H, L, L, H, L, H, Z32,          32'h0000_0400, 2'd0, H, 2'd3, 32'h0000_0400, H, H, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, L, Z32);
    // Halt over stall, then HALT ignores everything until reset.
    drive(L, H, L, L, L, L, H, Z32,          Z32,          2'd0, L, 2'd0, Z32,          L, H, L, Z32);
    drive(L, L, L, H, L, L, L, Z32,          Z32,          2'd3, L, 2'd0, Z32,          L, L, L, Z32);
    drive(L, H, H, L, H, H, H, 32'h0000_2000, 32'h0000_3010, 2'd3, L, 2'd0, Z32,       L, L, L, Z32);
    drive(H, L, L, H, L, L, L, Z32,          Z32,          2'd0, L, 2'd0, Z32,          H, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, H, Z32);
    // Reset in the middle of a stall.
    drive(L, H, L, L, L, L, L, Z32,          Z32,          2'd0, L, 2'd0, Z32,          L, H, L, Z32);
    drive(L, H, L, L, L, L, L, Z32,          Z32,          2'd1, L, 2'd0, Z32,          L, H, L, Z32);
    drive(H, H, L, L, L, L, L, Z32,          Z32,          2'd0, L, 2'd0, Z32,          H, L, L, Z32);
    drive(L, L, L, L, L, L, L, Z32,          Z32,          2'd0, H, 2'd0, Z32,          L, H, H, Z32);
    drive_done = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks = n_checks + 1;
      n_fails  = n_fails + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
